// File: rtl/normal_and_intersection_point_if.sv
// Handshake and data bundle between the intersection unit,
// this normal/hit-point stage and its consumer.
interface normal_and_intersection_point_if #(
  parameter int W = 32
);
  logic           start;
  logic [3*W-1:0] trig_v1;
  logic [3*W-1:0] trig_v2;
  logic [3*W-1:0] trig_v3;
  logic [3*W-1:0] ray_start;
  logic [3*W-1:0] ray_dir;
  logic [W-1:0]   t;
  logic           ready;
  logic [3*W-1:0] normal;
  logic [3*W-1:0] intersection_point;
  logic           degenerate;

  modport master (
    output start, trig_v1, trig_v2, trig_v3,
    output ray_start, ray_dir, t,
    input  ready, normal, intersection_point, degenerate
  );

  modport slave (
    input  start, trig_v1, trig_v2, trig_v3,
    input  ray_start, ray_dir, t,
    output ready, normal, intersection_point, degenerate
  );
endinterface

// File: rtl/normal_and_intersection_point.sv
// Ray-facing unit triangle normal and hit point P = start + t*dir,
// Q-format fixed point with bit-serial sqrt and divide.
module normal_and_intersection_point #(
  parameter int W         = 32,
  parameter int FRAC_BITS = 16
) (
  input logic clock,
  input logic reset,
  normal_and_intersection_point_if.slave bus
);
  localparam int XW   = 2*W + 2;
  localparam int W2   = 2*W;
  localparam int RADW = W + FRAC_BITS;
  localparam int SW   = RADW / 2;
  localparam int RMW  = SW + 4;
  localparam logic [5:0] SQ_LAST = 6'(SW - 1);
  localparam logic [5:0] DV_LAST = 6'(W - 1);
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

  typedef logic signed [XW-1:0] wide_t;
  typedef logic [W-1:0] word_t;

  typedef enum logic [3:0] {
    S_IDLE, S_EDGE, S_CROSS, S_ORIENT, S_SQSUM, S_SQRT,
    S_DIV_X, S_DIV_Y, S_DIV_Z, S_FINAL, S_DONE
  } state_t;

  function automatic wide_t sx(input word_t a);
    return wide_t'($signed(a));
  endfunction

  function automatic wide_t mulf(input word_t a, input word_t b);
    logic signed [W2-1:0] a2;
    logic signed [W2-1:0] b2;
    a2 = W2'($signed(a));
    b2 = W2'($signed(b));
    return wide_t'(a2 * b2);
  endfunction

  function automatic wide_t mulq(input word_t a, input word_t b);
    return mulf(a, b) >>> FRAC_BITS;
  endfunction

  function automatic word_t sat(input wide_t x);
    logic [XW-W:0] hi;
    hi = x[XW-1:W-1];
    if (&hi || ~|hi) return x[W-1:0];
    return x[XW-1] ? MINN : MAXP;
  endfunction

  state_t      r_state;
  logic [5:0]  r_cnt;
  word_t       r_e1 [3];
  word_t       r_e2 [3];
  word_t       r_n  [3];
  word_t       r_q  [3];
  word_t       r_s;
  logic [RADW-1:0] r_rad;
  logic [RMW-1:0]  r_rem;
  logic [SW-1:0]   r_root;
  logic [SW-1:0]   r_drem;
  word_t       r_dq;
  logic        r_ovf;
  logic        r_ready;
  logic        r_degen;
  logic [3*W-1:0] r_normal;
  logic [3*W-1:0] r_point;

  word_t w_v1 [3];
  word_t w_v2 [3];
  word_t w_v3 [3];
  word_t w_st [3];
  word_t w_dir [3];
  word_t w_cross [3];
  word_t w_pt [3];
  wide_t w_dot;
  logic  w_flip;
  word_t w_sqsum;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_v1[i]  = bus.trig_v1[(2-i)*W +: W];
      w_v2[i]  = bus.trig_v2[(2-i)*W +: W];
      w_v3[i]  = bus.trig_v3[(2-i)*W +: W];
      w_st[i]  = bus.ray_start[(2-i)*W +: W];
      w_dir[i] = bus.ray_dir[(2-i)*W +: W];
      w_pt[i]  = sat(sx(w_st[i]) + mulq(bus.t, w_dir[i]));
    end
    w_cross[0] = sat(mulq(r_e1[1], r_e2[2]) - mulq(r_e1[2], r_e2[1]));
    w_cross[1] = sat(mulq(r_e1[2], r_e2[0]) - mulq(r_e1[0], r_e2[2]));
    w_cross[2] = sat(mulq(r_e1[0], r_e2[1]) - mulq(r_e1[1], r_e2[0]));
    // Unshifted products so a tiny positive dot still flips.
    w_dot = mulf(r_n[0], w_dir[0]) + mulf(r_n[1], w_dir[1])
          + mulf(r_n[2], w_dir[2]);
    w_flip = !w_dot[XW-1] && (w_dot != '0);
    w_sqsum = sat(mulq(r_n[0], r_n[0]) + mulq(r_n[1], r_n[1])
                + mulq(r_n[2], r_n[2]));
  end

  logic            w_first;
  logic [RADW-1:0] w_rad_cur;
  logic [RMW-1:0]  w_rem_cur;
  logic [SW-1:0]   w_root_cur;
  logic [RMW+1:0]  w_rem_sh;
  logic [RMW+1:0]  w_trial;
  logic            w_sq_ge;
  logic [RMW-1:0]  w_rem_nx;
  logic [SW-1:0]   w_root_nx;

  assign w_first = (r_cnt == '0);

  always_comb begin
    w_rad_cur  = w_first ? {r_s, {FRAC_BITS{1'b0}}} : r_rad;
    w_rem_cur  = w_first ? '0 : r_rem;
    w_root_cur = w_first ? '0 : r_root;
    w_rem_sh   = {w_rem_cur, w_rad_cur[RADW-1 -: 2]};
    w_trial    = (RMW+2)'({w_root_cur, 2'b01});
    w_sq_ge    = (w_rem_sh >= w_trial);
    w_rem_nx   = w_sq_ge ? RMW'(w_rem_sh - w_trial) : RMW'(w_rem_sh);
    w_root_nx  = {w_root_cur[SW-2:0], w_sq_ge};
  end

  word_t         w_dn;
  logic          w_neg;
  word_t         w_abs;
  logic          w_ovf;
  logic [SW-1:0] w_drem_cur;
  word_t         w_dq_cur;
  logic [SW:0]   w_dr;
  logic          w_dge;
  logic [SW-1:0] w_dr_nx;
  word_t         w_quo;
  word_t         w_res;

  always_comb begin
    w_dn = r_n[0];
    unique case (1'b1)
      (r_state == S_DIV_Y): w_dn = r_n[1];
      (r_state == S_DIV_Z): w_dn = r_n[2];
      default:              w_dn = r_n[0];
    endcase
    w_neg = w_dn[W-1];
    w_abs = w_neg ? (~w_dn + 1'b1) : w_dn;
    // Dividend high part >= len means the quotient cannot fit.
    w_ovf = w_first ? (SW'(w_abs[W-1 -: FRAC_BITS]) >= r_root) : r_ovf;
    w_drem_cur = w_first ? SW'(w_abs[W-1 -: FRAC_BITS]) : r_drem;
    w_dq_cur   = w_first ? {w_abs[W-FRAC_BITS-1:0], {FRAC_BITS{1'b0}}}
                         : r_dq;
    w_dr    = {w_drem_cur, w_dq_cur[W-1]};
    w_dge   = (w_dr >= {1'b0, r_root});
    w_dr_nx = w_dge ? SW'(w_dr - {1'b0, r_root}) : w_dr[SW-1:0];
    w_quo   = {w_dq_cur[W-2:0], w_dge};
    w_res   = '0;
    if (r_root != '0) begin
      if (w_neg)
        w_res = (w_ovf || w_quo[W-1]) ? MINN : (~w_quo + 1'b1);
      else
        w_res = (w_ovf || w_quo[W-1]) ? MAXP : w_quo;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_s      <= '0;
      r_rad    <= '0;
      r_rem    <= '0;
      r_root   <= '0;
      r_drem   <= '0;
      r_dq     <= '0;
      r_ovf    <= 1'b0;
      r_ready  <= 1'b0;
      r_degen  <= 1'b0;
      r_normal <= '0;
      r_point  <= '0;
      for (int i = 0; i < 3; i++) begin
        r_e1[i] <= '0;
        r_e2[i] <= '0;
        r_n[i]  <= '0;
        r_q[i]  <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.start) r_state <= S_EDGE;
        S_EDGE: begin
          for (int i = 0; i < 3; i++) begin
            r_e1[i] <= sat(sx(w_v2[i]) - sx(w_v1[i]));
            r_e2[i] <= sat(sx(w_v3[i]) - sx(w_v1[i]));
          end
          r_state <= S_CROSS;
        end
        S_CROSS: begin
          for (int i = 0; i < 3; i++) r_n[i] <= w_cross[i];
          r_state <= S_ORIENT;
        end
        S_ORIENT: begin
          if (w_flip)
            for (int i = 0; i < 3; i++) r_n[i] <= sat(-sx(r_n[i]));
          r_state <= S_SQSUM;
        end
        S_SQSUM: begin
          r_s     <= w_sqsum;
          r_cnt   <= '0;
          r_state <= S_SQRT;
        end
        S_SQRT: begin
          r_rad  <= w_rad_cur << 2;
          r_rem  <= w_rem_nx;
          r_root <= w_root_nx;
          if (r_cnt == SQ_LAST) begin
            r_cnt   <= '0;
            r_state <= S_DIV_X;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_DIV_X, S_DIV_Y, S_DIV_Z: begin
          r_drem <= w_dr_nx;
          r_dq   <= w_quo;
          r_ovf  <= w_ovf;
          if (r_cnt == DV_LAST) begin
            r_cnt <= '0;
            if (r_state == S_DIV_X) begin
              r_q[0]  <= w_res;
              r_state <= S_DIV_Y;
            end else if (r_state == S_DIV_Y) begin
              r_q[1]  <= w_res;
              r_state <= S_DIV_Z;
            end else begin
              r_q[2]  <= w_res;
              r_state <= S_FINAL;
            end
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_FINAL: begin
          r_normal <= {r_q[0], r_q[1], r_q[2]};
          r_degen  <= (r_root == '0);
          r_point  <= {w_pt[0], w_pt[1], w_pt[2]};
          r_ready  <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (bus.start) begin
            r_ready <= 1'b0;
            r_state <= S_EDGE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready              = r_ready;
  assign bus.normal             = r_normal;
  assign bus.intersection_point = r_point;
  assign bus.degenerate         = r_degen;
endmodule

// File: tb/tb_normal_and_intersection_point.sv
// Directed bench: hand-computed normals, hit points, latency,
// busy-start immunity, mid-run reset and back-to-back restart.
module tb_normal_and_intersection_point;
  localparam int W = 32;
  localparam int LAT = 125;
  localparam logic [W-1:0] Z     = 32'h0000_0000;
  localparam logic [W-1:0] ONE   = 32'h0001_0000;
  localparam logic [W-1:0] MONE  = 32'hFFFF_0000;
  localparam logic [W-1:0] HALF  = 32'h0000_8000;
  localparam logic [W-1:0] MHALF = 32'hFFFF_8000;
  localparam logic [W-1:0] TWO   = 32'h0002_0000;
  localparam logic [W-1:0] ONEH  = 32'h0001_8000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  normal_and_intersection_point_if #(.W(W)) bus();

  normal_and_intersection_point #(.W(W), .FRAC_BITS(16)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int lat;
  logic rdy0;

  task automatic check(input string tag,
                       input logic [3*W-1:0] got,
                       input logic [3*W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [3*W-1:0] v3(input logic [W-1:0] x,
                                        input logic [W-1:0] y,
                                        input logic [W-1:0] z);
    return {x, y, z};
  endfunction

  task automatic setup(input logic [3*W-1:0] a, input logic [3*W-1:0] b,
                       input logic [3*W-1:0] c, input logic [3*W-1:0] s,
                       input logic [3*W-1:0] d, input logic [W-1:0] tt);
    bus.trig_v1   = a;
    bus.trig_v2   = b;
    bus.trig_v3   = c;
    bus.ray_start = s;
    bus.ray_dir   = d;
    bus.t         = tt;
  endtask

  // Cycle c counts edges after the one that samples start.
  task automatic go(input int pulse_at, input int hold,
                    output int l, output logic r0);
    bus.start = 1'b1;
    @(posedge clock); #1;
    r0 = bus.ready;
    if (hold == 0) bus.start = 1'b0;
    l = 0;
    for (int c = 1; c <= 200; c++) begin
      if (c == pulse_at) bus.start = 1'b1;
      @(posedge clock); #1;
      if (c == pulse_at || c >= hold) bus.start = 1'b0;
      if (bus.ready) begin
        l = c;
        break;
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    setup('0, '0, '0, '0, '0, '0);
    #2 reset = 1'b0;
    #10;
    check("rst_ready",  bus.ready, '0);
    check("rst_normal", bus.normal, '0);
    check("rst_point",  bus.intersection_point, '0);
    check("rst_degen",  bus.degenerate, '0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    setup(v3(Z,Z,Z), v3(TWO,Z,Z), v3(Z,TWO,Z),
          v3(MHALF,HALF,HALF), v3(ONE,Z,Z), ONE);
    go(0, 0, lat, rdy0);
    check("t1_lat",    (3*W)'(lat), (3*W)'(LAT));
    check("t1_normal", bus.normal, v3(Z,Z,ONE));
    check("t1_point",  bus.intersection_point, v3(HALF,HALF,HALF));
    check("t1_degen",  bus.degenerate, '0);
    repeat (3) @(posedge clock);
    #1;
    check("t1_hold_ready",  bus.ready, 1'b1);
    check("t1_hold_normal", bus.normal, v3(Z,Z,ONE));

    setup(v3(Z,Z,Z), v3(TWO,Z,Z), v3(Z,TWO,Z),
          v3(HALF,HALF,MONE), v3(Z,Z,ONE), ONE);
    go(0, 0, lat, rdy0);
    check("t2_rdy_drop", rdy0, 1'b0);
    check("t2_lat",      (3*W)'(lat), (3*W)'(LAT));
    check("t2_normal",   bus.normal, v3(Z,Z,MONE));
    check("t2_point",    bus.intersection_point, v3(HALF,HALF,Z));

    setup(v3(Z,Z,Z), v3(Z,Z,TWO), v3(Z,TWO,Z),
          v3(ONEH,HALF,HALF), v3(MONE,Z,Z), ONEH);
    go(0, 0, lat, rdy0);
    check("t3_lat",    (3*W)'(lat), (3*W)'(LAT));
    check("t3_normal", bus.normal, v3(ONE,Z,Z));
    check("t3_point",  bus.intersection_point, v3(Z,HALF,HALF));
    check("t3_degen",  bus.degenerate, '0);

    setup(v3(Z,Z,Z), v3(Z,Z,Z), v3(Z,TWO,Z),
          v3(MHALF,HALF,HALF), v3(ONE,Z,Z), ONE);
    go(0, 0, lat, rdy0);
    check("t4_lat",    (3*W)'(lat), (3*W)'(LAT));
    check("t4_degen",  bus.degenerate, 1'b1);
    check("t4_normal", bus.normal, '0);
    check("t4_point",  bus.intersection_point, v3(HALF,HALF,HALF));

    setup(v3(Z,Z,Z), v3(TWO,Z,Z), v3(Z,TWO,Z),
          v3(MHALF,HALF,HALF), v3(ONE,Z,Z), ONE);
    go(10, 0, lat, rdy0);
    check("t5_busy_lat",    (3*W)'(lat), (3*W)'(LAT));
    check("t5_busy_normal", bus.normal, v3(Z,Z,ONE));
    check("t5_busy_degen",  bus.degenerate, '0);

    setup(v3(Z,Z,Z), v3(TWO,Z,Z), v3(Z,TWO,Z),
          v3(HALF,HALF,MONE), v3(Z,Z,ONE), ONE);
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (59) @(posedge clock);
    #1;
    check("t5_mid_ready",  bus.ready, 1'b0);
    check("t5_mid_normal", bus.normal, v3(Z,Z,ONE));
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("t5_abort_ready",  bus.ready, '0);
    check("t5_abort_normal", bus.normal, '0);
    check("t5_abort_point",  bus.intersection_point, '0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    go(0, 0, lat, rdy0);
    check("t5_rerun_lat",    (3*W)'(lat), (3*W)'(LAT));
    check("t5_rerun_normal", bus.normal, v3(Z,Z,MONE));
    check("t5_rerun_point",  bus.intersection_point, v3(HALF,HALF,Z));

    setup(v3(Z,Z,Z), v3(Z,Z,TWO), v3(Z,TWO,Z),
          v3(ONEH,HALF,HALF), v3(MONE,Z,Z), ONEH);
    go(0, 5, lat, rdy0);
    check("t6_rdy_drop", rdy0, 1'b0);
    check("t6_lat",      (3*W)'(lat), (3*W)'(LAT));
    check("t6_normal",   bus.normal, v3(ONE,Z,Z));
    check("t6_point",    bus.intersection_point, v3(Z,HALF,HALF));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
